// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the buffered UART transmitter: register offsets in the
// UART window, STATUS bit positions and the serializer state encoding.
// The same offsets and bit positions are used by system_bus software drivers.
// -----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    // Byte offsets inside the UART window
    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;

    // STATUS register bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_BUSY    = 3;
    localparam int ST_CNT_LSB = 8;

    // Serializer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port (block-RAM friendly). Also
// intended for the receive path, so it carries no UART-specific logic.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data; ignored while full
//   pop             read request; ignored while empty. rdata is updated on the
//                   pop edge with the entry at the read pointer and then held.
//   full, empty     occupancy flags from the registered count
//   count           number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_rdata;

    // Full/empty come from the registered count only: a push while full is
    // dropped even if a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
        if (w_pop) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end

    // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter in the system_bus UART window. Stores to TXDATA
// queue bytes in a FIFO; the serializer drains it onto uart_txd back-to-back.
// STATUS lets software poll for room instead of stalling on the line rate.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   uart_addr    byte offset: 0x0 TXDATA (write byte), 0x4 STATUS
//   uart_wen     one-cycle write strobe
//   uart_wdata   [7:0] TXDATA byte, [2] STATUS overflow clear
//   uart_rdata   combinational read data (STATUS; everything else reads 0)
//   uart_txd     registered serial output, idles high
//   tx_busy      serializer not idle
//   overflow     sticky: a TXDATA write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uart_addr,
    input  logic        uart_wen,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW           = $clog2(DEPTH) + 1;

    tx_state_t      r_state;
    tx_state_t      w_state_next;
    logic [BW-1:0]  r_bcnt;
    logic [BW-1:0]  w_bcnt_next;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_next;
    logic           r_txd;
    logic           w_txd_next;
    logic           r_overflow;

    logic           w_push_req;
    logic           w_clr_req;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [7:0]     w_rd_byte;
    logic           w_bit_end;
    logic [31:0]    w_status;
    logic           w_unused_wdata;

    // Bus decode
    assign w_push_req = uart_wen && (uart_addr == UART_TXDATA_OFS);
    assign w_clr_req  = uart_wen && (uart_addr == UART_STATUS_OFS) && uart_wdata[2];
    assign w_unused_wdata = ^uart_wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .wdata (uart_wdata[7:0]),
        .rdata (w_rd_byte),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_bit_end = (r_bcnt == BW'(CLKS_PER_BIT - 1));

    // The popped byte stays in the FIFO read register for the whole frame, so
    // the data phase selects bits by index instead of keeping a separate copy.
    always_comb begin
        w_state_next   = r_state;
        w_bcnt_next    = w_bit_end ? '0 : r_bcnt + BW'(1);
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bcnt_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next frame when bytes are waiting.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Line level is derived from the next state so the output flop
        // changes on the same edge as the state.
        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_rd_byte[w_bit_idx_next];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bcnt     <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bcnt    <= w_bcnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            // A dropped push beats a simultaneous clear.
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr_req) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[ST_FULL]            = w_full;
        w_status[ST_EMPTY]           = w_empty;
        w_status[ST_OVF]             = r_overflow;
        w_status[ST_BUSY]            = tx_busy;
        w_status[ST_CNT_LSB +: CW]   = w_count;
    end

    assign uart_rdata = (uart_addr == UART_STATUS_OFS) ? w_status : 32'd0;
    assign uart_txd   = r_txd;
    assign tx_busy    = (r_state != S_IDLE);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=16. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A background monitor decodes frames on uart_txd into a queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 250;
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  uart_addr = 4'h0;
    logic        uart_wen = 1'b0;
    logic [31:0] uart_wdata = 32'h0;
    logic [31:0] uart_rdata;
    logic        uart_txd;
    logic        tx_busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_addr  (uart_addr),
        .uart_wen   (uart_wen),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .overflow   (overflow)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        $display("write addr=0x%0h data=0x%08h", a, d);
        uart_addr  = a;
        uart_wdata = d;
        uart_wen   = 1'b1;
        tick();
        uart_wen   = 1'b0;
    endtask

    // ---------------- frame monitor ----------------
    int         cyc = 0;
    int         mon_cnt = -1;
    int         mon_idx;
    logic [7:0] mon_sh = 8'h0;
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       stop_q[$];
    int         idle_cyc = -1;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mon_cnt   = -1;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !tx_busy) idle_cyc = cyc;
            prev_busy = tx_busy;
            if (mon_cnt < 0) begin
                if (uart_txd === 1'b0) begin
                    mon_cnt = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt = mon_cnt + 1;
                if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
                    mon_idx = (mon_cnt - 6) / 4;
                    mon_sh[mon_idx] = uart_txd;
                end
                if (mon_cnt == 38) begin
                    rx_q.push_back(mon_sh);
                    stop_q.push_back(uart_txd);
                    $display("rx byte=0x%02h stop=%0b cycle=%0d", mon_sh, uart_txd, cyc);
                    mon_cnt = -1;
                end
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
        stop_q.delete();
        idle_cyc = -1;
    endtask

    // Wait until the FIFO is empty and the serializer idle, bounded.
    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        uart_addr = 4'h4;
        @(negedge clk);
        while ((tx_busy || !uart_rdata[1]) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk_val("drain_in_time", 32'(n < max_cyc), 32'd1);
        tick();
    endtask

    task automatic chk_rx(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hFFFF_FFFF;
        chk_val(tag, got, 32'(exp));
        got = (idx < stop_q.size()) ? 32'(stop_q[idx]) : 32'hFFFF_FFFF;
        chk_val({tag, "_stop"}, got, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       exp_txd;
        logic       exp_busy;

        // ---- 1: reset state and ignored offsets ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("rst_status", uart_rdata, 32'h0000_0002);
        chk_val("rst_txd", 32'(uart_txd), 32'd1);
        chk_val("rst_busy", 32'(tx_busy), 32'd0);
        chk_val("rst_ovf", 32'(overflow), 32'd0);
        tick();
        bus_write(4'h8, 32'h0000_00FF);
        bus_write(4'hC, 32'h0000_005A);
        bus_write(4'h4, 32'h0000_00FF);
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("odd_ofs_ignored", uart_rdata, 32'h0000_0002);
        tick();

        // ---- 2: single byte 0xA5, cycle-exact ----
        clear_mon();
        b = 8'hA5;
        bus_write(4'h0, 32'h0000_00A5);
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5)       exp_txd = 1'b0;
            else if (c >= 6 && c <= 37) exp_txd = b[(c - 6) / 4];
            else                        exp_txd = 1'b1;
            exp_busy = (c >= 2 && c <= 41);
            chk_val($sformatf("a5_txd_c%0d", c), 32'(uart_txd), 32'(exp_txd));
            chk_val($sformatf("a5_busy_c%0d", c), 32'(tx_busy), 32'(exp_busy));
        end
        tick();

        // ---- 3: overfill, drop, sticky overflow and clear ----
        clear_mon();
        for (int i = 0; i < 18; i++) bus_write(4'h0, 32'(i));
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("full_status", uart_rdata, 32'h0000_100D);
        chk_val("ovf_set", 32'(overflow), 32'd1);
        uart_addr = 4'h0;
        #1;
        chk_val("txdata_reads0", uart_rdata, 32'h0);
        uart_addr = 4'hC;
        #1;
        chk_val("ofsC_reads0", uart_rdata, 32'h0);
        tick();
        bus_write(4'h4, 32'h0000_0003);
        @(negedge clk);
        chk_val("ovf_kept_bit2_0", 32'(overflow), 32'd1);
        tick();
        bus_write(4'h4, 32'h0000_0004);
        @(negedge clk);
        chk_val("ovf_cleared", 32'(overflow), 32'd0);
        chk_val("ovf_cleared_status", 32'(uart_rdata[2]), 32'd0);
        tick();
        wait_idle(1000);
        chk_val("ovf_rx_count", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 17; i++) chk_rx($sformatf("ovf_rx%0d", i), i, 8'(i));
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("drained_status", uart_rdata, 32'h0000_0002);
        tick();

        // ---- 4: back-to-back frames, no idle gap ----
        clear_mon();
        bus_write(4'h0, 32'h0000_003C);
        bus_write(4'h0, 32'h0000_00C3);
        wait_idle(300);
        chk_val("b2b_count", 32'(rx_q.size()), 32'd2);
        chk_rx("b2b_rx0", 0, 8'h3C);
        chk_rx("b2b_rx1", 1, 8'hC3);
        if (start_q.size() >= 2) begin
            chk_val("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd40);
            chk_val("b2b_idle_at", 32'(idle_cyc - start_q[0]), 32'd80);
        end else begin
            chk_val("b2b_starts", 32'(start_q.size()), 32'd2);
        end

        // ---- 5: reset during data bit 3 ----
        clear_mon();
        bus_write(4'h0, 32'h0000_0011);
        bus_write(4'h0, 32'h0000_0022);
        bus_write(4'h0, 32'h0000_0033);
        repeat (15) tick();
        @(negedge clk);
        chk_val("pre_rst_bit3", 32'(uart_txd), 32'd0);
        chk_val("pre_rst_busy", 32'(tx_busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("mid_rst_txd", 32'(uart_txd), 32'd1);
        chk_val("mid_rst_status", uart_rdata, 32'h0000_0002);
        tick();
        clear_mon();
        bus_write(4'h0, 32'h0000_0055);
        wait_idle(200);
        chk_val("post_rst_count", 32'(rx_q.size()), 32'd1);
        chk_rx("post_rst_rx", 0, 8'h55);

        // ---- 6: push coinciding with the chained pop ----
        clear_mon();
        for (int i = 0; i < 6; i++) bus_write(4'h0, 32'(8'h61 + i));
        repeat (34) tick();
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("cnt5_before", uart_rdata, 32'h0000_0508);
        tick();
        bus_write(4'h0, 32'h0000_0067);
        uart_addr = 4'h4;
        @(negedge clk);
        chk_val("cnt5_after_pushpop", uart_rdata, 32'h0000_0508);
        tick();
        wait_idle(400);
        chk_val("pp_count", 32'(rx_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk_rx($sformatf("pp_rx%0d", i), i, 8'(8'h61 + i));
        for (int i = 0; i + 1 < start_q.size(); i++)
            chk_val($sformatf("pp_gap%0d", i), 32'(start_q[i + 1] - start_q[i]), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
